// File: rtl/shifter_pkg.sv
// Shared types for the multi-cycle shift unit:
// operation encodings and controller states.
package shifter_pkg;

    typedef enum logic [1:0] {
        SHOP_SLL = 2'b00,
        SHOP_SRL = 2'b01,
        SHOP_SRA = 2'b10,
        SHOP_ROL = 2'b11
    } shop_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Single combinational shift step of up to STEP positions.
// Used once per RUN cycle by the sequencer.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] acc_i,
    input  shop_e            op_i,
    input  logic [SHW-1:0]   k_i,
    output logic [WIDTH-1:0] acc_o
);

    localparam logic [SHW-1:0] KMAX = SHW'(STEP);

    logic [SHW-1:0] k;
    logic [SHW:0]   ramt;

    // Never move more than one step's worth, whatever the caller asks.
    assign k    = (k_i > KMAX) ? KMAX : k_i;
    assign ramt = (SHW+1)'(WIDTH) - {1'b0, k};

    always_comb begin
        acc_o = acc_i;
        unique case (op_i)
            SHOP_SLL: acc_o = acc_i << k;
            SHOP_SRL: acc_o = acc_i >> k;
            SHOP_SRA: acc_o = WIDTH'($signed(acc_i) >>> k);
            SHOP_ROL: acc_o = (acc_i << k) | (acc_i >> ramt);
            default:  acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/shifter_seq.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROL by a run-time amount,
// STEP positions per cycle, start/busy/done handshake.
module shifter_seq
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o
);

    localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

    state_e           state_q, state_d;
    shop_e            op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [SHW-1:0]   rem_q, rem_d, rem_nxt, k;
    logic             accept;

    assign accept  = start_i && (state_q != RUN);
    assign k       = (rem_q < STEP_W) ? rem_q : STEP_W;
    assign rem_nxt = rem_q - k;

    shift_step #(
        .WIDTH(WIDTH),
        .STEP (STEP)
    ) u_step (
        .acc_i(acc_q),
        .op_i (op_q),
        .k_i  (k),
        .acc_o(acc_step)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = (shamt_i == '0) ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (rem_nxt == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == RUN);
        done_o = (state_q == DONE);
    end

    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        op_d  = op_q;
        if (accept) begin
            acc_d = data_i;
            rem_d = shamt_i;
            op_d  = shop_e'(op_i);
        end else if (state_q == RUN) begin
            acc_d = acc_step;
            rem_d = rem_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            rem_q <= '0;
            op_q  <= SHOP_SLL;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            op_q  <= op_d;
        end
    end

    assign data_o = acc_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Scoreboard bench for shifter_seq: STEP=1 and STEP=4 instances,
// directed vectors with hand-computed results, busy counts and latency.
module tb_shifter_seq;
    import shifter_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          nb;
        int          dcyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst4, start1, start4;
    logic [1:0]  op1, op4;
    logic [31:0] d1, d4;
    logic [4:0]  s1, s4;
    logic        busy1, busy4, done1, done4;
    logic [31:0] out1, out4;

    shifter_seq #(.WIDTH(32), .STEP(1)) u1 (
        .clk_i  (clk),
        .rst_i  (rst1),
        .start_i(start1),
        .op_i   (op1),
        .data_i (d1),
        .shamt_i(s1),
        .busy_o (busy1),
        .done_o (done1),
        .data_o (out1)
    );

    shifter_seq #(.WIDTH(32), .STEP(4)) u4 (
        .clk_i  (clk),
        .rst_i  (rst4),
        .start_i(start4),
        .op_i   (op4),
        .data_i (d4),
        .shamt_i(s4),
        .busy_o (busy4),
        .done_o (done4),
        .data_o (out4)
    );

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   bc1 = 0, bc4 = 0, ld1 = 0, ld4 = 0;
    exp_t q1[$];
    exp_t q4[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic on_done(input int id, input logic [31:0] act,
                           input int bc);
        exp_t e;
        int   sz;
        sz = (id == 1) ? q1.size() : q4.size();
        if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL u%0d_spurious_done: got done data %h expected no done",
                     id, act);
            return;
        end
        if (id == 1) e = q1.pop_front();
        else         e = q4.pop_front();
        chk($sformatf("u%0d_data", id), act, e.data);
        chk($sformatf("u%0d_busy_cycles", id), bc, e.nb);
        chk($sformatf("u%0d_done_cycle", id), cyc, e.dcyc);
    endtask

    always @(negedge clk) begin
        if (rst1) begin
            bc1 = 0;
        end else begin
            if (busy1) bc1++;
            if (done1) begin
                on_done(1, out1, bc1);
                bc1 = 0;
                ld1 = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (rst4) begin
            bc4 = 0;
        end else begin
            if (busy4) bc4++;
            if (done4) begin
                on_done(4, out4, bc4);
                bc4 = 0;
                ld4 = cyc;
            end
        end
    end

    function automatic logic busy_of(input int id);
        return (id == 1) ? busy1 : busy4;
    endfunction

    task automatic issue(input int id, input logic [1:0] op,
                         input logic [31:0] d, input logic [4:0] sh,
                         input logic [31:0] ed, input int nb,
                         input bit push, output int acc_cyc);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (busy_of(id) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL u%0d_issue_timeout: got busy for %0d cycles expected idle",
                     id, n);
        end
        if (id == 1) begin
            start1 = 1'b1; op1 = op; d1 = d; s1 = sh;
        end else begin
            start4 = 1'b1; op4 = op; d4 = d; s4 = sh;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (id == 1) start1 = 1'b0;
        else         start4 = 1'b0;
        if (push) begin
            e.data = ed;
            e.nb   = nb;
            e.dcyc = cyc + nb;
            if (id == 1) q1.push_back(e);
            else         q4.push_back(e);
        end
    endtask

    initial begin
        int a, a2, n;
        rst1 = 1'b1; rst4 = 1'b1;
        start1 = 1'b0; start4 = 1'b0;
        op1 = 2'b00; op4 = 2'b00;
        d1 = '0; d4 = '0; s1 = '0; s4 = '0;
        repeat (2) @(negedge clk);
        chk("u1_reset_data", out1, 32'h0);
        chk("u1_reset_ctl", 32'({busy1, done1}), 32'h0);
        chk("u4_reset_data", out4, 32'h0);
        chk("u4_reset_ctl", 32'({busy4, done4}), 32'h0);
        rst1 = 1'b0; rst4 = 1'b0;

        issue(1, SHOP_SLL, 32'h0000_0001, 5'd2,  32'h0000_0004, 2, 1, a);
        issue(1, SHOP_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, 4, 1, a);
        issue(1, SHOP_ROL, 32'h8000_0001, 5'd1,  32'h0000_0003, 1, 1, a);
        issue(1, SHOP_SRA, 32'h1234_5678, 5'd0,  32'h1234_5678, 0, 1, a);

        issue(4, SHOP_SRL, 32'hF000_0000, 5'd31, 32'h0000_0001, 8, 1, a);
        issue(4, SHOP_ROL, 32'h8000_0001, 5'd5,  32'h0000_0030, 2, 1, a);
        issue(4, SHOP_SRA, 32'h8000_0000, 5'd6,  32'hFE00_0000, 2, 1, a);
        issue(4, SHOP_SLL, 32'h0000_000F, 5'd28, 32'hF000_0000, 7, 1, a);

        // A start during RUN must be dropped without disturbing the result.
        issue(1, SHOP_SLL, 32'h0000_0003, 5'd3, 32'h0000_0018, 3, 1, a);
        @(negedge clk);
        start1 = 1'b1; op1 = 2'b01; d1 = 32'hFFFF_FFFF; s1 = 5'd1;
        @(negedge clk);
        start1 = 1'b0;

        issue(1, SHOP_SRL, 32'h0000_0100, 5'd4, 32'h0000_0010, 4, 1, a);
        issue(1, SHOP_ROL, 32'hC000_0000, 5'd2, 32'h0000_0003, 2, 1, a2);
        chk("u1_b2b_accept_cycle", a2, ld1 + 1);

        issue(1, SHOP_SLL, 32'h0000_0001, 5'd20, 32'h0, 0, 0, a);
        repeat (5) @(posedge clk);
        #2;
        rst1 = 1'b1;
        #1;
        chk("u1_midrun_rst_data", out1, 32'h0);
        chk("u1_midrun_rst_ctl", 32'({busy1, done1}), 32'h0);
        repeat (3) @(negedge clk);
        rst1 = 1'b0;
        issue(1, SHOP_SLL, 32'h0000_000A, 5'd3, 32'h0000_0050, 3, 1, a);

        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q1.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending results expected 0",
                     q1.size(), q4.size());
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
